// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory UART boot loader.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

  // Loader states, listed in the order a normal load walks through them.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loaderState_e;

  // UART receiver states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_e;

  // The core is held in reset whenever a load is in flight or has failed.
  function automatic logic holdsCore(input loaderState_e s);
    return !(s == ST_IDLE || s == ST_DONE);
  endfunction

endpackage

// File: rtl/imem_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, start-bit recheck.
//
// Handshake: byteValid is a one-cycle strobe with no ready. byteData is only
// meaningful in that cycle, and the consumer must take it then, because there
// is no backpressure. framingErr is a one-cycle strobe in place of byteValid
// when the stop bit is sampled low.
module imem_uart_rx
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxPin,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       framingErr
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  rxState_e      rxState;
  rxState_e      rxNext;
  logic [1:0]    syncFf;
  logic          rxPrev;
  logic          rxLine;
  logic [CW-1:0] timer;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;

  assign rxLine   = syncFf[1];
  assign byteData = shiftReg;

  // Next-state and stop-bit strobes; a start that is high again at half a bit is a glitch.
  always_comb begin
    rxNext     = rxState;
    byteValid  = 1'b0;
    framingErr = 1'b0;
    case (rxState)
      RX_IDLE:  if (rxPrev && !rxLine) rxNext = RX_START;
      RX_START: if (timer == HALF_CNT) rxNext = rxLine ? RX_IDLE : RX_DATA;
      RX_DATA:  if (timer == FULL_CNT && bitCnt == 3'd7) rxNext = RX_STOP;
      RX_STOP: begin
        if (timer == FULL_CNT) begin
          rxNext     = RX_IDLE;
          byteValid  = rxLine;
          framingErr = !rxLine;
        end
      end
      default:  rxNext = RX_IDLE;
    endcase
  end

  // Synchroniser, bit timer and LSB-first deserialiser.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncFf   <= 2'b11;
      rxPrev   <= 1'b1;
      rxState  <= RX_IDLE;
      timer    <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
    end else begin
      syncFf  <= {syncFf[0], rxPin};
      rxPrev  <= rxLine;
      rxState <= rxNext;
      if (rxState == RX_IDLE || rxNext != rxState || timer == FULL_CNT) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      if (rxState == RX_IDLE) begin
        bitCnt <= '0;
      end else if (rxState == RX_DATA && timer == FULL_CNT) begin
        bitCnt   <= bitCnt + 1'b1;
        shiftReg <= {rxLine, shiftReg[7:1]};
      end
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// UART boot loader: parses sync/length/data/checksum frames and writes words
// to SRAM port 0 from address 0 while holding the core in reset.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              load_en_i,
  input  logic              uart_rx_i,
  output logic              sram_csb0_o,
  output logic              sram_web0_o,
  output logic [ADDR_W-1:0] sram_addr0_o,
  output logic [DATA_W-1:0] sram_din0_o,
  output logic [3:0]        sram_wmask0_o,
  output logic              core_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  logic              byteValid;
  logic [7:0]        byteData;
  logic              framingErr;
  loaderState_e      state;
  loaderState_e      stateNext;
  logic [15:0]       lenQ;
  logic [1:0]        byteCnt;
  logic [ADDR_W-1:0] wordIdx;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wordReg;
  logic [7:0]        chkAcc;
  logic              doneQ;
  logic              errQ;
  logic              inLoad;
  logic              lenBad;
  logic              lastWord;

  imem_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .rxPin      (uart_rx_i),
    .byteValid  (byteValid),
    .byteData   (byteData),
    .framingErr (framingErr)
  );

  assign inLoad   = (state inside {ST_SYNC, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_CHK});
  assign lenBad   = (lenQ == 16'd0) || ({1'b0, lenQ} > MAX_WORDS);
  assign lastWord = (16'(wordIdx) == lenQ - 16'd1);

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= stateNext;
  end

  // Next state; load_en low wins over everything, including a byte landing this cycle.
  always_comb begin
    stateNext = state;
    if (!load_en_i) begin
      stateNext = ST_IDLE;
    end else if (inLoad && framingErr) begin
      stateNext = ST_ERR;
    end else begin
      case (state)
        ST_IDLE:   if (byteValid && byteData == SYNC_BYTE) stateNext = ST_SYNC;
        ST_SYNC:   if (byteValid) stateNext = ST_LEN_LO;
        ST_LEN_LO: if (byteValid) stateNext = ST_LEN_HI;
        ST_LEN_HI: stateNext = lenBad ? ST_ERR : ST_DATA;
        ST_DATA:   if (byteValid && byteCnt == 2'(BYTES_PER_WORD - 1)) stateNext = ST_WRITE;
        ST_WRITE:  stateNext = lastWord ? ST_CHK : ST_DATA;
        ST_CHK:    if (byteValid) stateNext = (byteData == chkAcc) ? ST_DONE : ST_ERR;
        default:   stateNext = state;
      endcase
    end
  end

  // Length capture, word assembly, checksum, address and sticky result flags.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lenQ    <= '0;
      byteCnt <= '0;
      wordIdx <= '0;
      addrQ   <= '0;
      wordReg <= '0;
      chkAcc  <= '0;
      doneQ   <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      if (state == ST_IDLE && stateNext == ST_SYNC) begin
        byteCnt <= '0;
        wordIdx <= '0;
        chkAcc  <= '0;
        doneQ   <= 1'b0;
        errQ    <= 1'b0;
      end
      if (state == ST_SYNC && byteValid)   lenQ[7:0]  <= byteData;
      if (state == ST_LEN_LO && byteValid) lenQ[15:8] <= byteData;
      if (state == ST_DATA && byteValid) begin
        wordReg <= {byteData, wordReg[DATA_W-1:8]};
        byteCnt <= byteCnt + 2'd1;
        chkAcc  <= chkAcc ^ byteData;
      end
      if (stateNext == ST_WRITE)              addrQ   <= wordIdx;
      if (state == ST_WRITE && !lastWord)     wordIdx <= wordIdx + 1'b1;
      if (state == ST_CHK && stateNext == ST_DONE) doneQ <= 1'b1;
      if (stateNext == ST_ERR && state != ST_ERR)  errQ  <= 1'b1;
    end
  end

  // SRAM port 0 is only selected during the single WRITE cycle.
  assign sram_csb0_o   = (state != ST_WRITE);
  assign sram_web0_o   = (state != ST_WRITE);
  assign sram_addr0_o  = addrQ;
  assign sram_din0_o   = wordReg;
  assign sram_wmask0_o = 4'hF;
  assign core_hold_o   = holdsCore(state);
  assign done_o        = doneQ;
  assign err_o         = errQ;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: frames are built as byte lists,
// a frame-level model predicts SRAM writes and the final verdict.
module tb_imem_uart_loader;

  localparam int CPB    = 16;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int MAX_N  = 2 ** ADDR_W;
  localparam int WR_W   = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              loadEn;
  logic              uartRx;
  logic              sram_csb0_o;
  logic              sram_web0_o;
  logic [ADDR_W-1:0] sram_addr0_o;
  logic [DATA_W-1:0] sram_din0_o;
  logic [3:0]        sram_wmask0_o;
  logic              core_hold_o;
  logic              done_o;
  logic              err_o;

  int                testsRun    = 0;
  int                testsFailed = 0;
  int                strayWeb    = 0;
  logic [WR_W-1:0]   expQ[$];
  logic [WR_W-1:0]   wrExp;
  logic [7:0]        txq[$];

  // Clock and reset
  always #5 clk = ~clk;

  imem_uart_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .load_en_i     (loadEn),
    .uart_rx_i     (uartRx),
    .sram_csb0_o   (sram_csb0_o),
    .sram_web0_o   (sram_web0_o),
    .sram_addr0_o  (sram_addr0_o),
    .sram_din0_o   (sram_din0_o),
    .sram_wmask0_o (sram_wmask0_o),
    .core_hold_o   (core_hold_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every selected SRAM cycle must match the next expected write.
  always @(negedge clk) begin
    if (!sram_web0_o && sram_csb0_o) strayWeb++;
    if (!sram_csb0_o) begin
      check("wr_expected", 64'(expQ.size() > 0), 64'd1);
      check("wr_web", 64'(sram_web0_o), 64'd0);
      check("wr_mask", 64'(sram_wmask0_o), 64'hF);
      if (expQ.size() > 0) begin
        wrExp = expQ.pop_front();
        check("wr_addr", 64'(sram_addr0_o), 64'(wrExp[WR_W-1:DATA_W]));
        check("wr_data", 64'(sram_din0_o), 64'(wrExp[DATA_W-1:0]));
      end
    end
  end

  // Driver: one 8N1 character, called and returning on a negative edge.
  task automatic sendByte(input logic [7:0] b, input bit badStop);
    uartRx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uartRx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uartRx = badStop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    uartRx = 1'b1;
    repeat ($urandom_range(1, 6)) @(negedge clk);
  endtask

  task automatic frameStart(input logic [15:0] n);
    txq.delete();
    txq.push_back(8'hA5);
    txq.push_back(n[7:0]);
    txq.push_back(n[15:8]);
  endtask

  task automatic pushWord(input logic [31:0] w);
    for (int k = 0; k < 4; k++) txq.push_back(8'(w >> (8 * k)));
  endtask

  task automatic pushChk(input logic [7:0] corrupt);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 3; i < txq.size(); i++) x = x ^ txq[i];
    txq.push_back(x ^ corrupt);
  endtask

  // Reference model: parse the whole frame, queue its writes, return 0 = done, 1 = error.
  task automatic modelLoad(output int outcome);
    int          n;
    logic [7:0]  x;
    logic [31:0] w;
    n = int'({txq[2], txq[1]});
    if (n == 0 || n > MAX_N) begin
      outcome = 1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = {txq[3+4*i+3], txq[3+4*i+2], txq[3+4*i+1], txq[3+4*i]};
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      expQ.push_back({ADDR_W'(i), w});
    end
    outcome = (txq[3+4*n] == x) ? 0 : 1;
  endtask

  task automatic finishLoad(input string tag, input int outcome);
    int t;
    t = 0;
    while (!(done_o || err_o) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_settle"}, 64'(done_o || err_o), 64'd1);
    check({tag, "_done"}, 64'(done_o), 64'(outcome == 0));
    check({tag, "_err"}, 64'(err_o), 64'(outcome == 1));
    check({tag, "_hold"}, 64'(core_hold_o), 64'(outcome == 1));
    check({tag, "_wr_left"}, 64'(expQ.size()), 64'd0);
    check({tag, "_stray_web"}, 64'(strayWeb), 64'd0);
    loadEn = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_hold_rel"}, 64'(core_hold_o), 64'd0);
    check({tag, "_sticky"}, 64'({done_o, err_o}), 64'({outcome == 0, outcome == 1}));
  endtask

  // Send txq with load_en high; optionally put a short idle-line glitch after byte glitchAfter.
  task automatic runFrame(input string tag, input int glitchAfter);
    int outcome;
    modelLoad(outcome);
    loadEn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < txq.size(); i++) begin
      sendByte(txq[i], 1'b0);
      if (i == glitchAfter) begin
        uartRx = 1'b0;
        repeat (5) @(negedge clk);
        uartRx = 1'b1;
        repeat (CPB * 12) @(negedge clk);
      end
    end
    finishLoad(tag, outcome);
  endtask

  initial begin
    logic [7:0] junk;
    rst    = 1'b1;
    loadEn = 1'b0;
    uartRx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_csb", 64'(sram_csb0_o), 64'd1);
    check("rst_web", 64'(sram_web0_o), 64'd1);
    check("rst_addr", 64'(sram_addr0_o), 64'd0);
    check("rst_din", 64'(sram_din0_o), 64'd0);
    check("rst_wmask", 64'(sram_wmask0_o), 64'hF);
    check("rst_hold", 64'(core_hold_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);

    // Two words, checksum derived from the data bytes.
    frameStart(16'd2);
    pushWord(32'h04030201);
    pushWord(32'hDEADBEEF);
    pushChk(8'h00);
    runFrame("two_words", -1);

    // One word with a wrong checksum byte of 0x00.
    frameStart(16'd1);
    pushWord(32'h11223344);
    txq.push_back(8'h00);
    runFrame("bad_chk", -1);

    // Length out of range.
    frameStart(16'h0000);
    runFrame("len_zero", -1);
    frameStart(16'h0201);
    runFrame("len_513", -1);
    frameStart(16'(MAX_N + 1));
    runFrame("len_max_p1", -1);

    // Stop bit low on the second data byte.
    loadEn = 1'b1;
    @(negedge clk);
    sendByte(8'hA5, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h12, 1'b0);
    sendByte(8'h34, 1'b1);
    finishLoad("framing", 1);

    // load_en dropped after the third data byte of word 0.
    loadEn = 1'b1;
    @(negedge clk);
    sendByte(8'hA5, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    check("drop_hold_before", 64'(core_hold_o), 64'd1);
    loadEn = 1'b0;
    @(negedge clk);
    check("drop_hold", 64'(core_hold_o), 64'd0);
    check("drop_flags", 64'({done_o, err_o}), 64'd0);
    check("drop_csb", 64'(sram_csb0_o), 64'd1);
    repeat (CPB * 4) @(negedge clk);
    check("drop_no_write", 64'(expQ.size()) + 64'(strayWeb), 64'd0);

    // Random frames, each preceded by a non-sync byte that IDLE must ignore.
    for (int r = 0; r < 4; r++) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h5A;
      loadEn = 1'b1;
      @(negedge clk);
      sendByte(junk, 1'b0);
      frameStart(16'($urandom_range(1, 4)));
      for (int w = 0; w < int'(txq[1]); w++) pushWord($urandom);
      pushChk(($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      runFrame("random", -1);
    end

    // Full memory of 0xFF words, checksum 0x00, glitch on the line after the length.
    frameStart(16'(MAX_N));
    for (int w = 0; w < MAX_N; w++) pushWord(32'hFFFFFFFF);
    txq.push_back(8'h00);
    runFrame("full", 2);
    check("full_last_addr", 64'(sram_addr0_o), 64'(MAX_N - 1));

    // Reset in the middle of a load.
    loadEn = 1'b1;
    @(negedge clk);
    sendByte(8'hA5, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h10, 1'b0);
    sendByte(8'h20, 1'b0);
    check("rst_mid_hold_before", 64'(core_hold_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_csb", 64'(sram_csb0_o), 64'd1);
    check("rst_mid_web", 64'(sram_web0_o), 64'd1);
    check("rst_mid_addr", 64'(sram_addr0_o), 64'd0);
    check("rst_mid_din", 64'(sram_din0_o), 64'd0);
    check("rst_mid_hold", 64'(core_hold_o), 64'd0);
    check("rst_mid_flags", 64'({done_o, err_o}), 64'd0);
    rst    = 1'b0;
    loadEn = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_no_write", 64'(expQ.size()) + 64'(strayWeb), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
